// File: rtl/register_pkg.sv
// Shared definitions for the register bank.
// Holds the operation-select encoding used by the bus interface, the bank top
// and every register cell.
package register_pkg;

    typedef logic [1:0] funsel_t;

    localparam funsel_t FUNSEL_CLEAR = 2'b00;
    localparam funsel_t FUNSEL_LOAD  = 2'b01;
    localparam funsel_t FUNSEL_DEC   = 2'b10;
    localparam funsel_t FUNSEL_INC   = 2'b11;

endpackage

// File: rtl/register_bank_if.sv
// Bus bundle between a datapath controller (master) and the register bank (slave).
//   funsel   : operation, see register_pkg
//   e        : per-register write mask
//   sat      : 1 = saturating inc/dec, 0 = wrap-around
//   i        : load data
//   flag_clr : clear all sticky overflow flags at the edge
//   osel_a/b : read selects
//   qa/qb    : read data (0 when select is out of range)
//   ovf      : sticky per-register overflow flags
//   zero     : per-register equals-zero flags
//   any_ovf  : OR of ovf
interface register_bank_if #(
    parameter int unsigned NBits = 16,
    parameter int unsigned NRegs = 4
);
    import register_pkg::*;

    localparam int unsigned SelBits = $clog2(NRegs);

    funsel_t            funsel;
    logic [NRegs-1:0]   e;
    logic               sat;
    logic [NBits-1:0]   i;
    logic               flag_clr;
    logic [SelBits-1:0] osel_a;
    logic [SelBits-1:0] osel_b;
    logic [NBits-1:0]   qa;
    logic [NBits-1:0]   qb;
    logic [NRegs-1:0]   ovf;
    logic [NRegs-1:0]   zero;
    logic               any_ovf;

    modport master (
        output funsel, e, sat, i, flag_clr, osel_a, osel_b,
        input  qa, qb, ovf, zero, any_ovf
    );

    modport slave (
        input  funsel, e, sat, i, flag_clr, osel_a, osel_b,
        output qa, qb, ovf, zero, any_ovf
    );

endinterface

// File: rtl/register_cell.sv
// One NBits register with its sticky overflow flag.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (q = ResetValue, ovf = 0)
//   funsel_i   : clear / load / decrement / increment
//   e_i        : enable; when low the cell holds (flag_clr still applies)
//   sat_i      : 1 = saturate at the limits, 0 = wrap
//   i_i        : load data
//   flag_clr_i : clear the sticky flag at the edge
//   q_o        : register contents
//   ovf_o      : sticky overflow/underflow flag
module register_cell
    import register_pkg::*;
#(
    parameter int unsigned      NBits      = 16,
    parameter logic [NBits-1:0] ResetValue = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  funsel_t          funsel_i,
    input  logic             e_i,
    input  logic             sat_i,
    input  logic [NBits-1:0] i_i,
    input  logic             flag_clr_i,
    output logic [NBits-1:0] q_o,
    output logic             ovf_o
);

    localparam logic [NBits-1:0] AllOnes = {NBits{1'b1}};
    localparam logic [NBits-1:0] One     = NBits'(1);

    logic [NBits-1:0] q_d, q_q;
    logic             ovf_d, ovf_q;

    always_comb begin
        q_d   = q_q;
        // Clearing first lets an overflow on the same edge win over flag_clr.
        ovf_d = ovf_q & ~flag_clr_i;
        if (e_i) begin
            case (funsel_i)
                FUNSEL_CLEAR: begin
                    q_d   = '0;
                    ovf_d = 1'b0;
                end
                FUNSEL_LOAD: begin
                    q_d = i_i;
                end
                FUNSEL_INC: begin
                    if (q_q == AllOnes) begin
                        ovf_d = 1'b1;
                        q_d   = sat_i ? AllOnes : '0;
                    end else begin
                        q_d = q_q + One;
                    end
                end
                FUNSEL_DEC: begin
                    if (q_q == '0) begin
                        ovf_d = 1'b1;
                        q_d   = sat_i ? '0 : AllOnes;
                    end else begin
                        q_d = q_q - One;
                    end
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= ResetValue;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q_o   = q_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/register_bank.sv
// Bank of NRegs general-purpose registers with clear/load/inc/dec, per-register
// write mask, wrap or saturating arithmetic, sticky overflow flags and two
// combinational read ports.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : register_bank_if slave (operation inputs, read selects, read data
//           and status flags)
module register_bank
    import register_pkg::*;
#(
    parameter int unsigned      NBits      = 16,
    parameter int unsigned      NRegs      = 4,
    parameter logic [NBits-1:0] ResetValue = '0
) (
    input logic             clk,
    input logic             rst_n,
    register_bank_if.slave  bus
);

    localparam int unsigned SelBits = $clog2(NRegs);

    logic [NBits-1:0] q [NRegs];
    logic [NRegs-1:0] ovf;
    logic [NBits-1:0] qa, qb;
    logic [NRegs-1:0] zero;

    for (genvar k = 0; k < NRegs; k++) begin : g_cell
        register_cell #(
            .NBits      (NBits),
            .ResetValue (ResetValue)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .funsel_i   (bus.funsel),
            .e_i        (bus.e[k]),
            .sat_i      (bus.sat),
            .i_i        (bus.i),
            .flag_clr_i (bus.flag_clr),
            .q_o        (q[k]),
            .ovf_o      (ovf[k])
        );
    end

    // Compare-and-select rather than indexing so selects >= NRegs fall out as 0.
    always_comb begin
        qa = '0;
        qb = '0;
        for (int unsigned k = 0; k < NRegs; k++) begin
            if (bus.osel_a == SelBits'(k)) qa = q[k];
            if (bus.osel_b == SelBits'(k)) qb = q[k];
        end
    end

    always_comb begin
        zero = '0;
        for (int unsigned k = 0; k < NRegs; k++) begin
            zero[k] = (q[k] == '0);
        end
    end

    assign bus.qa      = qa;
    assign bus.qb      = qb;
    assign bus.zero    = zero;
    assign bus.ovf     = ovf;
    assign bus.any_ovf = |ovf;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: a 4-register and a 3-register bank
// share one stimulus stream and are compared against an integer model.
module tb_register_bank;

    logic       clk;
    logic       rst_n;
    logic [1:0] fs;
    logic [3:0] en;
    logic       st;
    logic [3:0] din;
    logic       fc;
    logic [1:0] sa;
    logic [1:0] sb;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: d=0 is the 4-register bank, d=1 the 3-register bank.
    int mq [2][4];
    bit mo [2][4];
    int nr [2] = '{4, 3};

    register_bank_if #(.NBits(4), .NRegs(4)) bus4 ();
    register_bank_if #(.NBits(4), .NRegs(3)) bus3 ();

    assign bus4.funsel   = fs;
    assign bus4.e        = en;
    assign bus4.sat      = st;
    assign bus4.i        = din;
    assign bus4.flag_clr = fc;
    assign bus4.osel_a   = sa;
    assign bus4.osel_b   = sb;

    assign bus3.funsel   = fs;
    assign bus3.e        = en[2:0];
    assign bus3.sat      = st;
    assign bus3.i        = din;
    assign bus3.flag_clr = fc;
    assign bus3.osel_a   = sa;
    assign bus3.osel_b   = sb;

    register_bank #(.NBits(4), .NRegs(4), .ResetValue(4'h5)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    register_bank #(.NBits(4), .NRegs(3), .ResetValue(4'h5)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                mq[d][k] = 5;
                mo[d][k] = 1'b0;
            end
        end
    endfunction

    // One clock edge of the architectural behaviour, in plain integer arithmetic.
    function automatic void model_edge();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nr[d]; k++) begin
                int v;
                bit f;
                v = mq[d][k];
                f = mo[d][k] && !fc;
                if (en[k]) begin
                    case (fs)
                        2'b00: begin v = 0; f = 1'b0; end
                        2'b01: v = int'(din);
                        2'b11: begin
                            v = v + 1;
                            if (v > 15) begin f = 1'b1; v = st ? 15 : v - 16; end
                        end
                        default: begin
                            v = v - 1;
                            if (v < 0) begin f = 1'b1; v = st ? 0 : v + 16; end
                        end
                    endcase
                end
                mq[d][k] = v;
                mo[d][k] = f;
            end
        end
    endfunction

    function automatic logic [31:0] exp_read(input int d, input logic [1:0] s);
        return (int'(s) < nr[d]) ? 32'(mq[d][int'(s)]) : 32'd0;
    endfunction

    task automatic check_all(input string ph);
        for (int d = 0; d < 2; d++) begin
            logic [31:0] eo, ez, oqa, oqb, oov, oz, oany;
            eo = '0;
            ez = '0;
            for (int k = 0; k < nr[d]; k++) begin
                eo[k] = mo[d][k];
                ez[k] = (mq[d][k] == 0);
            end
            oqa  = (d == 0) ? 32'(bus4.qa)      : 32'(bus3.qa);
            oqb  = (d == 0) ? 32'(bus4.qb)      : 32'(bus3.qb);
            oov  = (d == 0) ? 32'(bus4.ovf)     : 32'(bus3.ovf);
            oz   = (d == 0) ? 32'(bus4.zero)    : 32'(bus3.zero);
            oany = (d == 0) ? 32'(bus4.any_ovf) : 32'(bus3.any_ovf);
            chk($sformatf("%s_d%0d_qa", ph, d), oqa, exp_read(d, sa));
            chk($sformatf("%s_d%0d_qb", ph, d), oqb, exp_read(d, sb));
            chk($sformatf("%s_d%0d_ovf", ph, d), oov, eo);
            chk($sformatf("%s_d%0d_zero", ph, d), oz, ez);
            chk($sformatf("%s_d%0d_any", ph, d), oany, 32'(eo != 0));
        end
    endtask

    // Checks the pre-edge read (no bypass), then the edge, then the result.
    task automatic cycle(input string ph);
        #1 check_all({ph, "_pre"});
        @(posedge clk);
        model_edge();
        #1 check_all(ph);
    endtask

    task automatic peek_a4(input string tag, input logic [1:0] s, input logic [31:0] exp_v);
        sa = s;
        #1 chk(tag, 32'(bus4.qa), exp_v);
    endtask

    initial begin
        rst_n = 1'b0;
        fs    = 2'b01;
        en    = 4'b0000;
        st    = 1'b0;
        din   = 4'h0;
        fc    = 1'b0;
        sa    = 2'd0;
        sb    = 2'd1;
        model_reset();

        // Reset values on every select
        #12 check_all("reset");
        for (int s = 0; s < 4; s++) begin
            sa = 2'(s);
            #0.1 chk($sformatf("reset_sel%0d", s), 32'(bus4.qa), 32'h5);
        end
        #0.5 rst_n = 1'b1;

        // Masked load then clear
        en = 4'b0101; fs = 2'b01; din = 4'hA;
        cycle("load");
        peek_a4("load_r0", 2'd0, 32'hA);
        peek_a4("load_r1", 2'd1, 32'h5);
        fs = 2'b00;
        cycle("clear");
        chk("clear_zero", 32'(bus4.zero), 32'b0101);

        // Wrap-around increment on R1
        en = 4'b0010; fs = 2'b01; din = 4'hE; sa = 2'd1;
        cycle("wrap_ld");
        fs = 2'b11; st = 1'b0;
        cycle("wrap1");
        chk("wrap1_r1", 32'(bus4.qa), 32'hF);
        chk("wrap1_ovf", 32'(bus4.ovf[1]), 32'd0);
        cycle("wrap2");
        chk("wrap2_r1", 32'(bus4.qa), 32'h0);
        chk("wrap2_ovf", 32'(bus4.ovf[1]), 32'd1);
        cycle("wrap3");
        chk("wrap3_r1", 32'(bus4.qa), 32'h1);
        chk("wrap3_ovf", 32'(bus4.ovf[1]), 32'd1);
        chk("wrap3_any", 32'(bus4.any_ovf), 32'd1);

        // Saturating decrement on R3
        en = 4'b1000; fs = 2'b01; din = 4'h1; sa = 2'd3;
        cycle("sat_ld");
        fs = 2'b10; st = 1'b1;
        cycle("sat1");
        chk("sat1_r3", 32'(bus4.qa), 32'h0);
        chk("sat1_ovf", 32'(bus4.ovf[3]), 32'd0);
        cycle("sat2");
        chk("sat2_r3", 32'(bus4.qa), 32'h0);
        chk("sat2_ovf", 32'(bus4.ovf[3]), 32'd1);
        cycle("sat3");
        chk("sat3_r3", 32'(bus4.qa), 32'h0);

        // Flag set wins over flag_clr on the same edge
        en = 4'b0001; fs = 2'b01; din = 4'hF; st = 1'b0; sa = 2'd0;
        cycle("prec_ld");
        fs = 2'b11; fc = 1'b1;
        cycle("prec_set");
        chk("prec_r0", 32'(bus4.qa), 32'h0);
        chk("prec_ovf", 32'(bus4.ovf), 32'b0001);
        en = 4'b0000;
        cycle("prec_clr");
        chk("prec_clr_ovf", 32'(bus4.ovf), 32'b0000);
        fc = 1'b0;

        // Out-of-range select and no write-through on the 3-register bank
        sa = 2'd3;
        #1 chk("oor_qa3", 32'(bus3.qa), 32'h0);
        en = 4'b0100; fs = 2'b01; din = 4'h7; sb = 2'd2;
        #1 chk("rdw_before", 32'(bus3.qb), 32'h0);
        cycle("rdw");
        chk("rdw_after", 32'(bus3.qb), 32'h7);

        // Asynchronous reset in the middle of an increment run
        en = 4'b1111; fs = 2'b11; st = 1'b0; sa = 2'd0;
        cycle("inc1");
        cycle("inc2");
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async");
        peek_a4("async_r0", 2'd0, 32'h5);
        rst_n = 1'b1;
        cycle("post_rst");
        chk("post_rst_r0", 32'(bus4.qa), 32'h6);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            fs  = 2'($urandom);
            en  = 4'($urandom);
            st  = 1'($urandom);
            din = 4'($urandom);
            fc  = ($urandom_range(0, 7) == 0);
            sa  = 2'($urandom);
            sb  = 2'($urandom);
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised bank of NRegs general-purpose registers. Each register supports clear, load, increment and decrement, with a per-register write mask, wrap or saturating arithmetic, sticky overflow flags and two independent read ports. It is the clocked successor of the single NBits function-select register and is the storage element the datapath uses for its general-purpose register file and address counters.

## Interface
- NBits, 16, register width in bits (≥2)
- NRegs, 4, number of registers (≥2; need not be a power of two)
- ResetValue, 0, value loaded into every register on reset (NBits wide)
- SelBits, $clog2(NRegs), derived read-select width; not overridden
- clk  in  1  clock, rising edge active
- rst_n  in  1  **reset, asynchronous, active-low**
- funsel  in  2  operation: 00 clear, 01 load, 10 decrement, 11 increment
- e  in  NRegs  write mask; bit k enables register k (any number of bits may be set)
- sat  in  1  1 = saturating inc/dec, 0 = wrap-around
- i  in  NBits  load data
- flag_clr  in  1  synchronous clear of all overflow flags
- osel_a  in  SelBits  read select, port A
- osel_b  in  SelBits  read select, port B
- qa  out  NBits  contents of register osel_a
- qb  out  NBits  contents of register osel_b
- ovf  out  NRegs  sticky per-register overflow/underflow flags
- zero  out  NRegs  bit k = 1 when register k equals 0
- any_ovf  out  1  OR of ovf

## Operation
- Reset (rst_n low, any time, independent of clk): all registers = ResetValue; ovf = 0. qa, qb, zero and any_ovf follow combinationally.
- At each rising clk, every register k with e[k]=1 executes funsel. Registers with e[k]=0 hold their value and their flag.
- Clear (00): register k = 0 and ovf[k] = 0.
- Load (01): register k = i. ovf[k] is unchanged.
- Increment (11):
  - Below all-ones: +1.
  - At all-ones with sat=0: wraps to 0 and sets ovf[k].
  - At all-ones with sat=1: holds all-ones and sets ovf[k].
- Decrement (10):
  - Above 0: −1.
  - At 0 with sat=0: wraps to all-ones and sets ovf[k].
  - At 0 with sat=1: holds 0 and sets ovf[k].
- Arithmetic is unsigned and modulo 2^NBits. No carry leaves the register; ovf is the only indication.
- flag_clr=1 clears all ovf bits at the clock edge.
  - If the same edge also sets ovf[k], set wins: ovf[k]=1 after the edge.
  - If the same edge clears register k (funsel 00), ovf[k] ends at 0.
- e=0 (all bits low): no state change, regardless of funsel, i or sat.
- Read ports are combinational from register state. osel values ≥ NRegs read as 0. Both ports may select the same register.

## Timing
- Write latency is 1 cycle. A value written at edge n is visible on qa/qb/zero from edge n onward (after clk-to-q).
- A read in the same cycle as a write returns the pre-write value. There is no write-through bypass.
- Flags update at the same edge as the register they describe. any_ovf is combinational from ovf.
- Reset asserted mid-operation overrides any in-flight funsel. The first edge after rst_n rises performs a normal operation.
- Inputs must be stable around rising clk only. No handshake; every enabled edge performs the operation.

## Structure
- Shared package register_pkg holds:
  - Funsel constants: FUNSEL_CLEAR=2'b00, FUNSEL_LOAD=2'b01, FUNSEL_DEC=2'b10, FUNSEL_INC=2'b11.
  - A funsel_t typedef.
- Sub-module register_cell: one NBits register with its sticky flag.
  - Ports: clk, rst_n, funsel, e, sat, i, flag_clr, q, ovf.
  - Instantiated NRegs times through a generate loop.
- register_bank contains only the cell array, the two read multiplexers with out-of-range zeroing, the zero detectors and the any_ovf reduction.

## Test plan
- Reset/clear/load (NBits=4, NRegs=4, ResetValue=4'h5):
  - After reset: qa=qb=5 for all selects; ovf=0.
  - e=4'b0101, funsel=01, i=4'hA for 1 edge → R0=R2=A, R1=R3=5.
  - Then funsel=00 → R0=R2=0, zero=4'b0101.
- Wrap: R1=4'hE, e=4'b0010, funsel=11, sat=0, 3 edges → R1 = F, 0, 1; ovf[1] set at the second edge and still set after the third; any_ovf=1.
- Saturate: R3=4'h1, funsel=10, sat=1, 3 edges → R3 = 0, 0, 0; ovf[3]=1 from the second edge.
- Flag precedence:
  - R0=F with funsel=11, sat=0, flag_clr=1 on the same edge → R0=0, ovf[0]=1, all other ovf bits 0.
  - Next edge with flag_clr=1 and e=0 → ovf=0.
- Read ports (NRegs=3): osel_a=3 → qa=0. Write R2=7 with osel_b=2 → qb shows the old value before the edge and 7 after.
- Async reset: assert rst_n low mid-cycle during an increment sequence → registers = ResetValue and ovf=0 immediately, without waiting for a clk edge. Release → the next edge increments from ResetValue.
